// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-gated instruction fetch with in-order response queue and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = AW + 4;
  typedef enum logic [1:0] {RESET, FETCH, FLUSH} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, resp_pc, target;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] occ, outst;
  logic [CW:0] used;
  logic [DW-1:0] drop_cnt, drop_nxt, drop_sum;
  logic [31:0] q_data [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic resp_in, acc, live, push, pop, full;
  assign target         = redirect_pc & ~32'd3;
  assign resp_in        = imem_resp_valid && state != RESET;
  assign used           = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid = state != RESET && !redirect_valid && used < (CW+1)'(DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign acc            = imem_req_valid && imem_req_ready;
  assign full           = occ == CW'(DEPTH);
  assign live           = resp_in && !redirect_valid && drop_cnt == '0;
  assign push           = live && !full;
  assign inst_valid     = occ != '0;
  assign inst_data      = q_data[head];
  assign inst_pc        = q_pc[head];
  assign pop            = inst_valid && inst_ready;
  assign drop_sum       = drop_cnt + DW'(outst);
  // stale responses still owed by memory: a redirect folds current credits in, each response retires one
  always_comb begin
    drop_nxt  = redirect_valid ? drop_sum - DW'(resp_in && drop_sum != '0)
                               : drop_cnt - DW'(resp_in && drop_cnt != '0);
    state_nxt = state == RESET ? FETCH : (drop_nxt != '0 ? FLUSH : FETCH);
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET;
    else state <= state_nxt;
  end
  // pointers, credits and fetch/response PCs; a redirect clears the queue after any same-cycle pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      outst    <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      resp_pc  <= target;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      outst    <= '0;
      drop_cnt <= drop_nxt;
    end else begin
      if (acc) fetch_pc <= fetch_pc + 32'd4;
      if (live) resp_pc <= resp_pc + 32'd4;
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      occ      <= occ + CW'(push) - CW'(pop);
      outst    <= outst + CW'(acc) - CW'(live && outst != '0);
      drop_cnt <= drop_nxt;
    end
  end
  // queue storage, written at the tail with the PC the response belongs to
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_resp_data;
      q_pc[tail]   <= resp_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue (DEPTH=4 and DEPTH=8 instances)
module tb_ifetch_queue;
  localparam logic [31:0] K = 32'hC0DE_0000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req_ready = 1'b0, imem_resp_valid = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] imem_resp_data = '0, redirect_pc = '0;
  logic r4_req_valid, r4_inst_valid, r8_req_valid, r8_inst_valid;
  logic [31:0] r4_req_addr, r4_inst_data, r4_inst_pc, r8_req_addr, r8_inst_data, r8_inst_pc;
  logic m_req_valid, m_inst_valid;
  logic [31:0] m_req_addr, m_inst_data, m_inst_pc;
  bit sel, mem_on;
  int checks = 0, fails = 0;
  logic [31:0] pend[$], reqs[$], got_pc[$], got_data[$];

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .imem_req_valid(r4_req_valid), .imem_req_addr(r4_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(r4_inst_valid),
    .inst_data(r4_inst_data), .inst_pc(r4_inst_pc), .inst_ready(inst_ready));

  ifetch_queue #(.DEPTH(8), .RESET_PC(32'h0000_0100)) u_dut8 (
    .clk(clk), .rst(rst), .imem_req_valid(r8_req_valid), .imem_req_addr(r8_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(r8_inst_valid),
    .inst_data(r8_inst_data), .inst_pc(r8_inst_pc), .inst_ready(inst_ready));

  assign m_req_valid  = sel ? r8_req_valid  : r4_req_valid;
  assign m_req_addr   = sel ? r8_req_addr   : r4_req_addr;
  assign m_inst_valid = sel ? r8_inst_valid : r4_inst_valid;
  assign m_inst_data  = sel ? r8_inst_data  : r4_inst_data;
  assign m_inst_pc    = sel ? r8_inst_pc    : r4_inst_pc;

  task automatic cyc();
    logic a, p;
    logic [31:0] aa, ppc, pd;
    imem_resp_valid = mem_on && pend.size() > 0;
    imem_resp_data  = imem_resp_valid ? pend[0] ^ K : 32'h0;
    #1;
    a = m_req_valid && imem_req_ready;
    aa = m_req_addr;
    p = m_inst_valid && inst_ready;
    ppc = m_inst_pc;
    pd = m_inst_data;
    @(posedge clk);
    if (imem_resp_valid) void'(pend.pop_front());
    if (a) begin pend.push_back(aa); reqs.push_back(aa); end
    if (p) begin got_pc.push_back(ppc); got_data.push_back(pd); end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit s);
    sel = s; rst = 1'b0; mem_on = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0; imem_resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pend.delete(); reqs.delete(); got_pc.delete(); got_data.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (m_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", m_req_valid); end
    checks++; if (m_inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b expected 0", m_inst_valid); end
    do_reset(1'b0);
    #1;
    checks++; if (m_req_valid !== 1'b0) begin fails++; $display("FAIL reset_state_no_req: got %b expected 0", m_req_valid); end
    cyc();
    #1;
    checks++; if (m_req_valid !== 1'b1) begin fails++; $display("FAIL first_req_valid: got %b expected 1", m_req_valid); end
    checks++; if (m_req_addr !== 32'h0) begin fails++; $display("FAIL first_req_addr: got %h expected 00000000", m_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] v;
    do_reset(1'b0);
    mem_on = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (12) cyc();
    checks++; if (reqs.size() != 11) begin fails++; $display("FAIL stream_req_count: got %0d expected 11", reqs.size()); end
    checks++; if (got_pc.size() != 9) begin fails++; $display("FAIL stream_throughput: got %0d expected 9", got_pc.size()); end
    for (int i = 0; i < 9; i++) begin
      v = i < got_pc.size() ? got_pc[i] : 32'hx;
      checks++; if (v !== 32'(4 * i)) begin fails++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, v, 32'(4 * i)); end
      v = i < got_data.size() ? got_data[i] : 32'hx;
      checks++; if (v !== (32'(4 * i) ^ K)) begin fails++; $display("FAIL stream_data[%0d]: got %h expected %h", i, v, 32'(4 * i) ^ K); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    do_reset(1'b0);
    mem_on = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (10) cyc();
    #1;
    checks++; if (reqs.size() != 4) begin fails++; $display("FAIL bp_req_count: got %0d expected 4", reqs.size()); end
    checks++; if (m_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_stalled: got %b expected 0", m_req_valid); end
    checks++; if (m_inst_valid !== 1'b1 || m_inst_pc !== 32'h0) begin fails++; $display("FAIL bp_head: got valid %b pc %h expected 1 00000000", m_inst_valid, m_inst_pc); end
    inst_ready = 1'b1;
    cyc();
    #1;
    checks++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h10) begin fails++; $display("FAIL bp_resume: got valid %b addr %h expected 1 00000010", m_req_valid, m_req_addr); end
    repeat (8) cyc();
    for (int i = 0; i < 8; i++) begin
      v = i < got_pc.size() ? got_pc[i] : 32'hx;
      checks++; if (v !== 32'(4 * i)) begin fails++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, v, 32'(4 * i)); end
      v = i < got_data.size() ? got_data[i] : 32'hx;
      checks++; if (v !== (32'(4 * i) ^ K)) begin fails++; $display("FAIL bp_data[%0d]: got %h expected %h", i, v, 32'(4 * i) ^ K); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] v;
    int n = 0;
    do_reset(1'b0);
    imem_req_ready = 1'b1; inst_ready = 1'b1; mem_on = 1'b0;
    while (reqs.size() < 3 && n < 20) begin cyc(); n++; end
    imem_req_ready = 1'b0;
    checks++; if (reqs.size() != 3) begin fails++; $display("FAIL redir_outstanding: got %0d expected 3", reqs.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h1002;
    #1;
    checks++; if (m_req_valid !== 1'b0) begin fails++; $display("FAIL redir_req_blocked: got %b expected 0", m_req_valid); end
    cyc();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_on = 1'b1;
    #1;
    checks++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h1000) begin fails++; $display("FAIL redir_target: got valid %b addr %h expected 1 00001000", m_req_valid, m_req_addr); end
    repeat (10) cyc();
    for (int i = 0; i < 2; i++) begin
      v = i < got_pc.size() ? got_pc[i] : 32'hx;
      checks++; if (v !== 32'h1000 + 32'(4 * i)) begin fails++; $display("FAIL redir_pc[%0d]: got %h expected %h", i, v, 32'h1000 + 32'(4 * i)); end
      v = i < got_data.size() ? got_data[i] : 32'hx;
      checks++; if (v !== ((32'h1000 + 32'(4 * i)) ^ K)) begin fails++; $display("FAIL redir_data[%0d]: got %h expected %h", i, v, (32'h1000 + 32'(4 * i)) ^ K); end
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] v;
    do_reset(1'b0);
    mem_on = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (3) cyc();
    mem_on = 1'b0;
    repeat (2) cyc();
    checks++; if (reqs.size() != 4) begin fails++; $display("FAIL rpop_setup: got %0d expected 4", reqs.size()); end
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h2000; inst_ready = 1'b1; mem_on = 1'b1;
    cyc();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (m_inst_valid !== 1'b0) begin fails++; $display("FAIL rpop_flushed: got %b expected 0", m_inst_valid); end
    repeat (12) cyc();
    v = got_pc.size() > 0 ? got_pc[0] : 32'hx;
    checks++; if (v !== 32'h0) begin fails++; $display("FAIL rpop_old_head_pc: got %h expected 00000000", v); end
    v = got_data.size() > 0 ? got_data[0] : 32'hx;
    checks++; if (v !== K) begin fails++; $display("FAIL rpop_old_head_data: got %h expected %h", v, K); end
    for (int i = 0; i < 2; i++) begin
      v = i + 1 < got_pc.size() ? got_pc[i+1] : 32'hx;
      checks++; if (v !== 32'h2000 + 32'(4 * i)) begin fails++; $display("FAIL rpop_pc[%0d]: got %h expected %h", i, v, 32'h2000 + 32'(4 * i)); end
      v = i + 1 < got_data.size() ? got_data[i+1] : 32'hx;
      checks++; if (v !== ((32'h2000 + 32'(4 * i)) ^ K)) begin fails++; $display("FAIL rpop_data[%0d]: got %h expected %h", i, v, (32'h2000 + 32'(4 * i)) ^ K); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] v;
    do_reset(1'b0);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_on = 1'b1; inst_ready = 1'b1;
    repeat (8) cyc();
    for (int i = 0; i < 3; i++) begin
      v = i < reqs.size() ? reqs[i] : 32'hx;
      checks++; if (v !== exp_a[i]) begin fails++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, v, exp_a[i]); end
      v = i < got_pc.size() ? got_pc[i] : 32'hx;
      checks++; if (v !== exp_a[i]) begin fails++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, v, exp_a[i]); end
      v = i < got_data.size() ? got_data[i] : 32'hx;
      checks++; if (v !== (exp_a[i] ^ K)) begin fails++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, v, exp_a[i] ^ K); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset(1'b1);
    mem_on = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (5) cyc();
    mem_on = 1'b0;
    cyc();
    imem_req_ready = 1'b0;
    #1;
    checks++; if (reqs.size() != 5) begin fails++; $display("FAIL rmid_setup: got %0d expected 5", reqs.size()); end
    checks++; if (m_inst_valid !== 1'b1 || m_inst_pc !== 32'h100) begin fails++; $display("FAIL rmid_head: got valid %b pc %h expected 1 00000100", m_inst_valid, m_inst_pc); end
    rst = 1'b0;
    #1;
    checks++; if (m_inst_valid !== 1'b0) begin fails++; $display("FAIL rmid_async_inst_valid: got %b expected 0", m_inst_valid); end
    checks++; if (m_req_valid !== 1'b0) begin fails++; $display("FAIL rmid_async_req_valid: got %b expected 0", m_req_valid); end
    mem_on = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    pend.delete(); reqs.delete(); got_pc.delete(); got_data.delete();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (8) cyc();
    v = reqs.size() > 0 ? reqs[0] : 32'hx;
    checks++; if (v !== 32'h100) begin fails++; $display("FAIL rmid_first_req: got %h expected 00000100", v); end
    for (int i = 0; i < 2; i++) begin
      v = i < got_pc.size() ? got_pc[i] : 32'hx;
      checks++; if (v !== 32'h100 + 32'(4 * i)) begin fails++; $display("FAIL rmid_pc[%0d]: got %h expected %h", i, v, 32'h100 + 32'(4 * i)); end
      v = i < got_data.size() ? got_data[i] : 32'hx;
      checks++; if (v !== ((32'h100 + 32'(4 * i)) ^ K)) begin fails++; $display("FAIL rmid_data[%0d]: got %h expected %h", i, v, (32'h100 + 32'(4 * i)) ^ K); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
